// File: rtl/keypad_pkg.sv
// Shared types and keymap for the 4x4 matrix keypad scanner.
// Pure declarations: no latency, no flow control.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Keypad legend: digits as themselves, A-D as 10-13, '*' as 14, '#' as 15.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = 4'd14;
      4'b11_01: code = 4'd0;
      4'b11_10: code = 4'd15;
      4'b11_11: code = 4'd13;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // True when exactly one row line is pulled low (single key in the column).
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Index of the low row line; only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous front-panel inputs; resets to all-ones (idle pull-up).
// Latency 2 cycles; no flow control.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one KEY_PRESS pulse + ITEM_CODE per debounced press.
// Latency <= 2 + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles; no backpressure, pulse is fire-and-forget.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] ROW_IN,
  output logic [3:0] COL_OUT,
  output logic       KEY_PRESS,
  output logic [3:0] ITEM_CODE,
  output logic       KEY_HELD
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0] rows_s;

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             key_press_q, key_press_d;
  logic [3:0]       item_code_q, item_code_d;
  logic             key_held_q, key_held_d;

  sync_2ff #(
    .WIDTH(4)
  ) u_row_sync (
    .clk  (CLK),
    .rst_n(RESET_N),
    .d    (ROW_IN),
    .q    (rows_s)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      row_pat_q   <= ROWS_IDLE;
      row_idx_q   <= 2'd0;
      key_press_q <= 1'b0;
      item_code_q <= 4'd0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      row_pat_q   <= row_pat_d;
      row_idx_q   <= row_idx_d;
      key_press_q <= key_press_d;
      item_code_q <= item_code_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    row_pat_d   = row_pat_q;
    row_idx_d   = row_idx_q;
    key_press_d = 1'b0;
    item_code_d = item_code_q;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          // Multi-key (ghost) patterns are dropped just like an idle column.
          if (single_low(rows_s)) begin
            row_pat_d = rows_s;
            row_idx_d = low_index(rows_s);
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (rows_s != row_pat_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          // Outputs are loaded here so they are visible during the PRESSED cycle.
          state_d     = PRESSED;
          cnt_d       = '0;
          key_press_d = 1'b1;
          item_code_d = keymap(row_idx_q, col_q);
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end

      RELEASE: begin
        // Any key in the held column restarts the release window: no auto-repeat.
        if (rows_s != ROWS_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = SCAN;
          key_held_d = 1'b0;
          col_d      = col_q + 2'd1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  assign COL_OUT   = ~(4'b0001 << col_q);
  assign KEY_PRESS = key_press_q;
  assign ITEM_CODE = item_code_q;
  assign KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives ROW_IN from COL_OUT,
// expected codes are queued at stimulus time and popped by a pulse monitor.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_press;
  logic [3:0]  item_code;
  logic        key_held;

  // key_down[r*4+c] = key at row r, column c is physically closed.
  logic [15:0] key_down;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_exp;
  logic prev_kp = 1'b0;

  always #5 clk = ~clk;

  assign row_in = {~|(key_down[15:12] & ~col_out),
                   ~|(key_down[11:8]  & ~col_out),
                   ~|(key_down[7:4]   & ~col_out),
                   ~|(key_down[3:0]   & ~col_out)};

  keypad_scanner dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .ROW_IN   (row_in),
    .COL_OUT  (col_out),
    .KEY_PRESS(key_press),
    .ITEM_CODE(item_code),
    .KEY_HELD (key_held)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n = cycles until KEY_PRESS seen, or limit+1 if it never came.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (key_press === 1'b1) return;
    end
    n = limit + 1;
  endtask

  task automatic wait_held_low(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (key_held === 1'b0) return;
    end
    n = limit + 1;
  endtask

  task automatic wait_col(input logic [3:0] want, input int limit, output int n);
    n = 0;
    while (n < limit && col_out !== want) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (col_out !== want) n = limit + 1;
  endtask

  task automatic wait_col_change(input int limit, output int n);
    logic [3:0] start;
    start = col_out;
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (col_out !== start) return;
    end
    n = limit + 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},  32'(col_out),   32'(4'b1110));
    check({tag, "_kp"},   32'(key_press), 32'd0);
    check({tag, "_code"}, 32'(item_code), 32'd0);
    check({tag, "_held"}, 32'(key_held),  32'd0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard and last one cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_press === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual code=%0d required=no pulse", item_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse_code", 32'(item_code), 32'(mon_exp));
      end
      check("pulse_width_prev_low", 32'(prev_kp), 32'd0);
    end
    prev_kp = key_press;
  end

  logic [3:0] col_seq [4];

  initial begin
    int n;
    col_seq[0] = 4'b1101;
    col_seq[1] = 4'b1011;
    col_seq[2] = 4'b0111;
    col_seq[3] = 4'b1110;

    key_down = '0;
    rst_n    = 1'b0;

    // Reset with the row lines toggling underneath.
    for (int i = 0; i < 3; i++) begin
      key_down[0] = ~key_down[0];
      key_down[4] = ~key_down[4];
      tick(1);
      check_reset_vals("reset");
    end
    key_down = '0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Clean press of '6' (row 1, col 2), held ~60 cycles.
    exp_q.push_back(6);
    key_down[6] = 1'b1;
    wait_pulse(40, n);
    check("six_latency_le27", 32'(n <= 27), 32'd1);
    check("six_held", 32'(key_held), 32'd1);
    tick(60 - n);
    check("six_held_late", 32'(key_held), 32'd1);
    check("six_no_repeat_code", 32'(item_code), 32'd6);
    key_down[6] = 1'b0;
    wait_held_low(30, n);
    check("six_release_cycles", 32'(n), 32'd10);

    // Bouncing '0' (row 3, col 1): 10 toggles of 3 cycles, then held.
    for (int i = 0; i < 10; i++) begin
      key_down[13] = ~key_down[13];
      tick(3);
    end
    check("bounce_no_held", 32'(key_held), 32'd0);
    exp_q.push_back(0);
    key_down[13] = 1'b1;
    wait_pulse(40, n);
    check("zero_latency_le27", 32'(n <= 27), 32'd1);
    check("zero_after_stable", 32'(n >= 10), 32'd1);
    key_down[13] = 1'b0;
    wait_held_low(30, n);
    check("zero_release_cycles", 32'(n), 32'd10);

    // Ghost: rows 0 and 2 both low in col 0 -> rejected, scanning continues.
    key_down[0] = 1'b1;
    key_down[8] = 1'b1;
    wait_col(4'b1110, 20, n);
    check("ghost_found_col0", 32'(n <= 20), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_col_change(10, n);
      check("ghost_col_seq", 32'(col_out), 32'(col_seq[i]));
      if (i > 0) check("ghost_dwell", 32'(n), 32'd4);
    end
    tick(20);
    check("ghost_no_held", 32'(key_held), 32'd0);
    key_down = '0;
    tick(4);

    // Controller sequence: '1' then '7'.
    exp_q.push_back(1);
    key_down[0] = 1'b1;
    wait_pulse(40, n);
    check("one_latency_le27", 32'(n <= 27), 32'd1);
    key_down[0] = 1'b0;
    wait_held_low(30, n);
    check("one_release_cycles", 32'(n), 32'd10);
    check("one_code_hold_a", 32'(item_code), 32'd1);
    tick(15);
    check("one_code_hold_b", 32'(item_code), 32'd1);
    exp_q.push_back(7);
    key_down[8] = 1'b1;
    wait_pulse(40, n);
    check("seven_latency_le27", 32'(n <= 27), 32'd1);
    check("seven_code", 32'(item_code), 32'd7);
    key_down[8] = 1'b0;
    wait_held_low(30, n);
    check("seven_release_cycles", 32'(n), 32'd10);

    // Reset during debounce of '#' (row 3, col 2), key still held afterwards.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    key_down[14] = 1'b1;
    wait_col(4'b1011, 20, n);
    check("hash_reach_col2", 32'(n <= 20), 32'd1);
    tick(6);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    tick(3);
    exp_q.push_back(15);
    rst_n = 1'b1;
    wait_pulse(40, n);
    check("hash_latency_le27", 32'(n <= 27), 32'd1);
    check("hash_held", 32'(key_held), 32'd1);
    key_down[14] = 1'b0;
    wait_held_low(30, n);
    check("hash_release_cycles", 32'(n), 32'd10);
    tick(5);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
